// File: rtl/arbitro_wrr.sv
// Input-FIFO demux plus a weighted-round-robin / strict-priority drain arbiter over NUM_CH
// virtual-channel FIFOs. The arbiter state (cur, credit) freezes while any output FIFO is almost full.
module arbitro_wrr #(
  parameter int NUM_CH   = 4,
  parameter int DEST_W   = 2,
  parameter int WEIGHT_W = 3
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         mode,
  input  logic [NUM_CH*WEIGHT_W-1:0]   weights,
  input  logic [DEST_W-1:0]            dest,
  input  logic                         empty_in,
  input  logic [NUM_CH-1:0]            almost_full,
  input  logic [NUM_CH-1:0]            empty,
  input  logic [NUM_CH-1:0]            almost_empty,
  output logic [NUM_CH-1:0]            push,
  output logic                         pop_in,
  output logic [NUM_CH-1:0]            pop,
  output logic                         valid
);

  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]   r_pop;
  logic                r_valid;
  logic [CW-1:0]       r_cur;
  logic [WEIGHT_W-1:0] r_credit;

  logic [NUM_CH-1:0]   w_elig;
  logic [NUM_CH-1:0]   w_pop_nxt;
  logic [CW-1:0]       w_cur_nxt;
  logic [WEIGHT_W-1:0] w_credit_nxt;
  logic [CW-1:0]       w_idx;
  logic                w_found;

  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int k);
    return CW'((int'(a) + k) % NUM_CH);
  endfunction

  // A dest beyond NUM_CH-1 never matches any channel, so it yields no push.
  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset_L && !empty_in && (dest == DEST_W'(i)) && !almost_full[i])
        push[i] = 1'b1;
    end
  end

  assign pop_in = |push;

  // A pop registered now lands next cycle, so a channel with one word left must skip a cycle.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_elig[i] = !empty[i]
                  && (mode || (weights[i*WEIGHT_W +: WEIGHT_W] != '0))
                  && !(r_pop[i] && almost_empty[i]);
    end
  end

  always_comb begin
    w_pop_nxt    = '0;
    w_cur_nxt    = r_cur;
    w_credit_nxt = r_credit;
    w_idx        = r_cur;
    w_found      = 1'b0;
    if (|almost_full) begin
      w_pop_nxt = '0;
    end else if (mode) begin
      w_credit_nxt = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (w_elig[i]) begin
          w_idx   = CW'(i);
          w_found = 1'b1;
        end
      end
      if (w_found) begin
        w_pop_nxt[w_idx] = 1'b1;
        w_cur_nxt        = w_idx;
      end
    end else if (w_elig[r_cur] && (r_credit != '0)) begin
      w_pop_nxt[r_cur] = 1'b1;
      w_credit_nxt     = r_credit - WEIGHT_W'(1);
    end else begin
      // Scan downward so the nearest channel after cur wins; cur itself is checked last.
      for (int k = NUM_CH; k >= 1; k--) begin
        if (w_elig[wrap_add(r_cur, k)]) begin
          w_idx   = wrap_add(r_cur, k);
          w_found = 1'b1;
        end
      end
      if (w_found) begin
        w_pop_nxt[w_idx] = 1'b1;
        w_cur_nxt        = w_idx;
        w_credit_nxt     = weights[w_idx*WEIGHT_W +: WEIGHT_W] - WEIGHT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_pop    <= '0;
      r_valid  <= 1'b0;
      r_cur    <= CW'(NUM_CH - 1);
      r_credit <= '0;
    end else begin
      r_pop    <= w_pop_nxt;
      r_valid  <= |r_pop;
      r_cur    <= w_cur_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  assign pop   = r_pop;
  assign valid = r_valid;

endmodule

// File: tb/tb_arbitro_wrr.sv
// Scoreboard bench for arbitro_wrr: stimulus queues the hand-computed pop/valid for every edge,
// a negedge monitor pops and compares; the combinational push path is checked inline.
module tb_arbitro_wrr;
  localparam int N  = 4;
  localparam int DW = 2;
  localparam int WW = 3;

  logic            clk = 1'b0;
  logic            reset_L;
  logic            mode;
  logic [N*WW-1:0] weights;
  logic [DW-1:0]   dest;
  logic            empty_in;
  logic [N-1:0]    almost_full;
  logic [N-1:0]    empty;
  logic [N-1:0]    almost_empty;
  logic [N-1:0]    push;
  logic            pop_in;
  logic [N-1:0]    pop;
  logic            valid;

  always #5 clk = ~clk;

  arbitro_wrr #(.NUM_CH(N), .DEST_W(DW), .WEIGHT_W(WW)) dut (
    .clk(clk), .reset_L(reset_L), .mode(mode), .weights(weights), .dest(dest),
    .empty_in(empty_in), .almost_full(almost_full), .empty(empty),
    .almost_empty(almost_empty), .push(push), .pop_in(pop_in), .pop(pop), .valid(valid)
  );

  typedef struct packed {
    logic [N-1:0] pop;
    logic         valid;
  } exp_t;

  exp_t     q[$];
  exp_t     me;
  int       n_chk = 0;
  int       n_err = 0;
  logic [N-1:0] prev_pop = '0;

  // Queue the expected result of the coming edge, then advance one cycle.
  task automatic step(input logic [N-1:0] ep);
    exp_t e;
    e.pop    = ep;
    e.valid  = reset_L ? (|prev_pop) : 1'b0;
    q.push_back(e);
    prev_pop = ep;
    @(posedge clk);
    #1;
  endtask

  task automatic rep(input logic [N-1:0] ep, input int n);
    for (int i = 0; i < n; i++) step(ep);
  endtask

  task automatic check_push(input string name, input logic [N-1:0] ep);
    #1;
    n_chk++;
    if (push !== ep || pop_in !== (|ep)) begin
      n_err++;
      $display("FAIL %s: got push=%b pop_in=%b, expected push=%b pop_in=%b",
               name, push, pop_in, ep, |ep);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      n_chk++;
      if (pop !== me.pop || valid !== me.valid) begin
        n_err++;
        $display("FAIL pop_seq @%0t: got pop=%b valid=%b, expected pop=%b valid=%b",
                 $time, pop, valid, me.pop, me.valid);
      end
    end
  end

  initial begin
    reset_L      = 1'b0;
    mode         = 1'b0;
    weights      = {3'd1, 3'd2, 3'd3, 3'd4};
    dest         = '0;
    empty_in     = 1'b1;
    almost_full  = '0;
    empty        = '0;
    almost_empty = '0;
    rep(4'b0000, 2);
    reset_L = 1'b1;

    // WRR with weights 4,3,2,1
    repeat (2) begin
      rep(4'b0001, 4); rep(4'b0010, 3); rep(4'b0100, 2); rep(4'b1000, 1);
    end

    // stall mid ch0 burst, resume with remaining credit
    rep(4'b0001, 2);
    almost_full = 4'b0010;
    rep(4'b0000, 3);
    almost_full = '0;
    rep(4'b0001, 2); rep(4'b0010, 3); rep(4'b0100, 2); rep(4'b1000, 1);

    // channels 1 and 2 empty
    empty = 4'b0110;
    repeat (2) begin
      rep(4'b0001, 4); rep(4'b1000, 1);
    end
    empty = '0;

    // weight 0 masks channel 2
    weights = {3'd1, 3'd0, 3'd3, 3'd4};
    repeat (2) begin
      rep(4'b0001, 4); rep(4'b0010, 3); rep(4'b1000, 1);
    end

    // strict priority
    mode  = 1'b1;
    empty = 4'b0001;
    rep(4'b0010, 3);
    empty = '0;
    rep(4'b0001, 2);

    // strict -> WRR: cur=0, credit=0, search starts at ch1
    weights = {3'd1, 3'd2, 3'd3, 3'd4};
    mode    = 1'b0;
    rep(4'b0010, 3); rep(4'b0100, 2); rep(4'b1000, 1); rep(4'b0001, 1);

    // sole channel with one word left: pop every other cycle
    empty        = 4'b1101;
    almost_empty = 4'b0010;
    rep(4'b0010, 1); rep(4'b0000, 1); rep(4'b0010, 1); rep(4'b0000, 1);

    // push path, with nothing eligible to pop
    empty        = 4'b1111;
    almost_empty = '0;
    empty_in     = 1'b0;
    dest         = 2'd2;
    check_push("push_dest2", 4'b0100);
    almost_full = 4'b0100;
    check_push("push_af_dest", 4'b0000);
    almost_full = 4'b1000;
    check_push("push_af_other", 4'b0100);
    dest = 2'd3;
    check_push("push_af_dest3", 4'b0000);
    almost_full = '0;
    check_push("push_dest3", 4'b1000);
    empty_in = 1'b1;
    check_push("push_empty_in", 4'b0000);
    rep(4'b0000, 2);

    // reset in the middle of a ch2 burst
    empty = '0;
    rep(4'b0010, 1); rep(4'b0100, 1);
    reset_L  = 1'b0;
    empty_in = 1'b0;
    dest     = 2'd2;
    check_push("push_in_reset", 4'b0000);
    empty_in = 1'b1;
    rep(4'b0000, 1);
    reset_L = 1'b1;
    rep(4'b0001, 4); rep(4'b0010, 1);

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
